// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS-subset controller: instruction
// field constants, datapath select encodings, the controller state set and dispatch.
package mips_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] RTYPE = 6'h00;
  localparam logic [5:0] J     = 6'h02;
  localparam logic [5:0] JAL   = 6'h03;
  localparam logic [5:0] BNE   = 6'h05;
  localparam logic [5:0] ADDI  = 6'h08;
  localparam logic [5:0] XORI  = 6'h0E;
  localparam logic [5:0] LW    = 6'h23;
  localparam logic [5:0] SW    = 6'h2B;

  // R-type funct codes (instr[5:0]); ADD is encoded as 0x00 in this subset
  localparam logic [5:0] R_ADD = 6'h00;
  localparam logic [5:0] R_JR  = 6'h08;
  localparam logic [5:0] R_SUB = 6'h22;
  localparam logic [5:0] R_SLT = 6'h2A;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  // PC source select
  localparam logic [1:0] PC_INC4 = 2'd0;
  localparam logic [1:0] PC_J    = 2'd1;
  localparam logic [1:0] PC_JR   = 2'd2;
  localparam logic [1:0] PC_BNE  = 2'd3;

  // Register write data select
  localparam logic [1:0] REG_DIN_ALU = 2'd0;
  localparam logic [1:0] REG_DIN_DM  = 2'd1;
  localparam logic [1:0] REG_DIN_JAL = 2'd2;

  // ALU B input select
  localparam logic [1:0] ALUB_RT     = 2'd0;
  localparam logic [1:0] ALUB_FOUR   = 2'd1;
  localparam logic [1:0] ALUB_IMM    = 2'd2;
  localparam logic [1:0] ALUB_IMMSH2 = 2'd3;

  // ALU A input select
  localparam logic ALUA_PC = 1'b0;
  localparam logic ALUA_RS = 1'b1;

  // Register write address select
  localparam logic [1:0] WADDR_RT = 2'd0;
  localparam logic [1:0] WADDR_RD = 2'd1;
  localparam logic [1:0] WADDR_RA = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADDR = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXECR   = 4'd7,
    S_WBR     = 4'd8,
    S_EXECI   = 4'd9,
    S_WBI     = 4'd10,
    S_BRANCH  = 4'd11,
    S_JUMP    = 4'd12,
    S_JUMPR   = 4'd13
  } state_t;

  // State following DECODE; S_FETCH marks an unsupported instruction.
  function automatic state_t dispatch(input logic [5:0] opc, input logic [5:0] fn);
    state_t nxt;
    nxt = S_FETCH;
    case (opc)
      LW, SW:     nxt = S_MEMADDR;
      ADDI, XORI: nxt = S_EXECI;
      J, JAL:     nxt = S_JUMP;
      BNE:        nxt = S_BRANCH;
      RTYPE: begin
        case (fn)
          R_ADD, R_SUB, R_SLT: nxt = S_EXECR;
          R_JR:                nxt = S_JUMPR;
          default:             nxt = S_FETCH;
        endcase
      end
      default:    nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle controller for the MIPS-subset datapath sharing one memory port.
// Outputs are decoded from the state register, gated by memReady/aluZero where needed.
module multicycle_ctrl
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        resetN,
  input  logic        run,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        aluZero,
  input  logic        memReady,
  output logic        memReq,
  output logic        memWe,
  output logic        iOrD,
  output logic        irWe,
  output logic        pcWe,
  output logic [1:0]  pcSrcCtrl,
  output logic        aluASrc,
  output logic [1:0]  aluBSrc,
  output logic [2:0]  op,
  output logic        regWe,
  output logic [1:0]  regWAddrSel,
  output logic [1:0]  regDInCtrl,
  output logic        illegal,
  output logic        instrDone,
  output logic [31:0] retired
);

  state_t state;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= S_IDLE;
      retired <= 32'd0;
    end else begin
      if (instrDone)
        retired <= retired + 32'd1;
      case (state)
        S_IDLE:    if (run) state <= S_FETCH;
        S_FETCH:   if (memReady) state <= S_DECODE;
        S_DECODE:  state <= dispatch(opcode, funct);
        S_MEMADDR: state <= (opcode == LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:   if (memReady) state <= S_MEMWB;
        S_MEMWR:   if (memReady) state <= S_FETCH;
        S_EXECR:   state <= S_WBR;
        S_EXECI:   state <= S_WBI;
        // Write-back, branch and jump states all finish the instruction.
        default:   state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    memReq      = 1'b0;
    memWe       = 1'b0;
    iOrD        = 1'b0;
    irWe        = 1'b0;
    pcWe        = 1'b0;
    pcSrcCtrl   = PC_INC4;
    aluASrc     = ALUA_PC;
    aluBSrc     = ALUB_RT;
    op          = ALU_ADD;
    regWe       = 1'b0;
    regWAddrSel = WADDR_RT;
    regDInCtrl  = REG_DIN_ALU;
    illegal     = 1'b0;
    instrDone   = 1'b0;
    case (state)
      S_FETCH: begin
        memReq  = 1'b1;
        aluBSrc = ALUB_FOUR;
        irWe    = memReady;
        pcWe    = memReady;
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        aluBSrc = ALUB_IMMSH2;
        illegal = (dispatch(opcode, funct) == S_FETCH);
      end
      S_MEMADDR: begin
        aluASrc = ALUA_RS;
        aluBSrc = ALUB_IMM;
      end
      S_MEMRD: begin
        memReq = 1'b1;
        iOrD   = 1'b1;
      end
      S_MEMWB: begin
        regWe      = 1'b1;
        regDInCtrl = REG_DIN_DM;
        instrDone  = 1'b1;
      end
      S_MEMWR: begin
        memReq    = 1'b1;
        memWe     = 1'b1;
        iOrD      = 1'b1;
        instrDone = memReady;
      end
      S_EXECR: begin
        aluASrc = ALUA_RS;
        case (funct)
          R_SUB:   op = ALU_SUB;
          R_SLT:   op = ALU_SLT;
          default: op = ALU_ADD;
        endcase
      end
      S_WBR: begin
        regWe       = 1'b1;
        regWAddrSel = WADDR_RD;
        instrDone   = 1'b1;
      end
      S_EXECI: begin
        aluASrc = ALUA_RS;
        aluBSrc = ALUB_IMM;
        op      = (opcode == XORI) ? ALU_XOR : ALU_ADD;
      end
      S_WBI: begin
        regWe     = 1'b1;
        instrDone = 1'b1;
      end
      S_BRANCH: begin
        aluASrc   = ALUA_RS;
        op        = ALU_SUB;
        pcSrcCtrl = PC_BNE;
        pcWe      = ~aluZero;
        instrDone = 1'b1;
      end
      S_JUMP: begin
        pcSrcCtrl = PC_J;
        pcWe      = 1'b1;
        instrDone = 1'b1;
        // JAL links the already-incremented PC into r31.
        if (opcode == JAL) begin
          regWe       = 1'b1;
          regWAddrSel = WADDR_RA;
          regDInCtrl  = REG_DIN_JAL;
        end
      end
      S_JUMPR: begin
        pcSrcCtrl = PC_JR;
        pcWe      = 1'b1;
        instrDone = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
